// File: rtl/st_uart_tx.sv
// Avalon-ST byte sink that buffers bytes in a small circular FIFO and sends them as 8N1 UART frames.
// Frames go out back-to-back while the FIFO holds data. Backpressure is applied while the FIFO is full.
module st_uart_tx #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               asi_valid,
  input  logic [7:0]         asi_data,
  output logic               asi_ready,
  output logic               txd,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LVL_W = FIFO_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_txd;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bitcnt;
  logic [7:0]         r_shift;
  logic [LVL_W-1:0]   r_level;
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [7:0]         r_mem [FIFO_DEPTH];

  state_t             w_state_nxt;
  logic               w_txd_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [2:0]         w_bitcnt_nxt;
  logic [7:0]         w_shift_nxt;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_bit_end;
  logic               w_has_data;
  logic [7:0]         w_head;

  // Ready depends only on the registered level; a same-edge pop does not free a slot early.
  assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_has_data = (r_level != '0);
  assign w_push     = asi_valid && !w_full;
  assign w_bit_end  = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_head     = r_mem[r_rptr];

  assign asi_ready  = !w_full;
  assign txd        = r_txd;
  assign busy       = (r_state != S_IDLE) || w_has_data;
  assign fifo_level = r_level;

  // Next-state, serial output and bit datapath.
  always_comb begin
    w_state_nxt  = r_state;
    w_txd_nxt    = r_txd;
    w_cnt_nxt    = w_bit_end ? '0 : (r_cnt + CNT_W'(1));
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_pop        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_txd_nxt = 1'b1;
        if (w_has_data) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_txd_nxt   = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_txd_nxt    = r_shift[0];
          w_shift_nxt  = {1'b0, r_shift[7:1]};
          w_bitcnt_nxt = 3'd0;
          w_state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bitcnt == 3'd7) begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_txd_nxt    = r_shift[0];
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          // Chain straight into the next start bit when more bytes are waiting.
          if (w_has_data) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_txd_nxt   = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_txd_nxt   = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM and serialiser registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_txd    <= 1'b1;
      r_cnt    <= '0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_txd    <= w_txd_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
    end
  end

  // FIFO pointers and occupancy; resetting the pointers flushes the contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= asi_data;
  end

endmodule

// File: tb/tb_st_uart_tx.sv
// Randomised bench for st_uart_tx: a frame-level reference model predicts txd, level, ready and busy every clock.
// It covers idle reset, a single byte, a burst under backpressure, random streams and reset in mid-frame.
module tb_st_uart_tx;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned AW      = 2;
  localparam int          FRAME   = 10 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        asi_valid = 1'b0;
  logic [7:0]  asi_data = 8'h00;
  logic        asi_ready;
  logic        txd;
  logic        busy;
  logic [AW:0] fifo_level;

  always #5 clk = ~clk;

  st_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .asi_valid  (asi_valid),
    .asi_data   (asi_data),
    .asi_ready  (asi_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: accepted-byte queue, occupancy, and position inside the current 40-sample frame.
  logic [7:0] m_q[$];
  logic [7:0] s_q[$];
  logic [7:0] m_cur = 8'h00;
  int         m_level = 0;
  bit         m_in_frame = 1'b0;
  int         m_pos = 0;
  bit         last_push = 1'b0;
  int         n_pushed = 0;
  int         n_frames = 0;
  bit         full_seen = 1'b0;
  int         push_base = 0;
  int         acc_at_full = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    int k;
    k = pos / CLK_DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_level    = 0;
    m_in_frame = 1'b0;
    m_pos      = 0;
    last_push  = 1'b0;
  endtask

  // One clock: advance the model using the inputs present at the edge, then compare.
  task automatic step();
    bit         v;
    logic [7:0] d;
    bit         push;
    bit         start;
    logic       exp_txd;
    v     = asi_valid;
    d     = asi_data;
    push  = v && (m_level != DEPTH);
    start = (!m_in_frame || m_pos == FRAME - 1) && (m_level > 0);
    @(posedge clk);
    #1;
    if (push) begin
      m_q.push_back(d);
      n_pushed++;
    end
    if (m_in_frame && m_pos == FRAME - 1) n_frames++;
    if (start) begin
      m_cur      = m_q.pop_front();
      m_in_frame = 1'b1;
      m_pos      = 0;
    end else if (m_in_frame && m_pos < FRAME - 1) begin
      m_pos++;
    end else begin
      m_in_frame = 1'b0;
    end
    m_level   = m_level + int'(push) - int'(start);
    last_push = push;
    if (!full_seen && m_level == DEPTH) begin
      full_seen   = 1'b1;
      acc_at_full = n_pushed - push_base;
    end
    exp_txd = m_in_frame ? frame_bit(m_cur, m_pos) : 1'b1;
    chk("txd", 32'(txd), 32'(exp_txd));
    chk("fifo_level", 32'(fifo_level), 32'(m_level));
    chk("asi_ready", 32'(asi_ready), 32'(m_level != DEPTH));
    chk("busy", 32'(busy), 32'(m_in_frame || m_level != 0));
  endtask

  // Source: holds a byte stable until accepted, otherwise inserts random gaps.
  task automatic drive_next(input int gap_pct);
    if (last_push) void'(s_q.pop_front());
    if (asi_valid && !last_push) begin
      asi_valid = 1'b1;
    end else if (s_q.size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
      asi_valid = 1'b1;
      asi_data  = s_q[0];
    end else begin
      asi_valid = 1'b0;
      asi_data  = 8'($urandom);
    end
  endtask

  task automatic run(input int cycles, input int gap_pct);
    repeat (cycles) begin
      step();
      drive_next(gap_pct);
    end
  endtask

  task automatic drain(input string tag, input int bound, input int gap_pct);
    int n;
    bit done;
    n = 0;
    done = (s_q.size() == 0) && !asi_valid && !m_in_frame && (m_level == 0);
    while (!done && n < bound) begin
      step();
      drive_next(gap_pct);
      n++;
      done = (s_q.size() == 0) && !asi_valid && !m_in_frame && (m_level == 0);
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    bit reached;
    int n;

    // Idle after reset release.
    #22 rstn = 1'b1;
    run(100, 0);

    // Single byte.
    s_q.push_back(8'hA5);
    drive_next(0);
    drain("drain_single", 200, 0);
    run(3, 0);

    // Continuous burst into backpressure, then back-to-back frames.
    full_seen = 1'b0;
    push_base = n_pushed;
    for (int i = 1; i <= 6; i++) s_q.push_back(8'(i));
    drive_next(0);
    drain("drain_burst", 600, 0);
    chk("accepted_before_full", 32'(acc_at_full), 32'd5);

    // Random streams with gaps; exercises push coinciding with STOP->START pops.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 30; i++) s_q.push_back(8'($urandom));
      drive_next(10 + 30 * r);
      drain("drain_random", 3000, 10 + 30 * r);
    end

    // Reset during data bit 3 of 0x3C, with a byte still queued.
    s_q.push_back(8'h3C);
    s_q.push_back(8'h99);
    drive_next(0);
    n = 0;
    reached = 1'b0;
    while (!reached && n < 200) begin
      step();
      drive_next(0);
      n++;
      reached = m_in_frame && (m_pos == 4 * CLK_DIV + 1) && (m_cur == 8'h3C);
    end
    chk("reach_bit3", 32'(reached), 32'd1);
    #2 rstn = 1'b0;
    asi_valid = 1'b0;
    #1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(asi_ready), 32'd1);
    s_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    n_pushed = 0;
    n_frames = 0;
    run(5, 0);
    s_q.push_back(8'h55);
    drive_next(0);
    drain("drain_after_reset", 200, 0);
    chk("frames_vs_pushed", 32'(n_frames), 32'(n_pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
